// File: rtl/pattern_gen_fifo_if.sv
// FIFO write-port bundle between the pattern generator (master) and the
// downstream user data FIFO (slave).
interface pattern_gen_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] TEST_OUT;
    logic                  WR_EN;
    logic                  FIFO_FULL;

    modport master (
        output TEST_OUT,
        output WR_EN,
        input  FIFO_FULL
    );

    modport slave (
        input  TEST_OUT,
        input  WR_EN,
        output FIFO_FULL
    );
endinterface

// File: rtl/pattern_gen_fifo.sv
// Test-pattern source: streams {frame_cnt, word_idx} words into a FIFO write
// port in one-shot, continuous or gapped-burst mode, honouring FIFO_FULL.
module pattern_gen_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [1:0]           MODE,
    input  logic [CNT_WIDTH-1:0] LIMIT,
    input  logic [GAP_WIDTH-1:0] GAP,
    pattern_gen_fifo_if.master   fifo,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [31:0]          WORD_TOTAL
);
    localparam int FRAME_WIDTH = DATA_WIDTH - CNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_ONESHOT    = 2'd0,
        M_CONTINUOUS = 2'd1,
        M_BURST      = 2'd2,
        M_RESERVED   = 2'd3
    } mode_t;

    state_t                 state_q;
    state_t                 state_d;
    mode_t                  mode_q;
    logic [CNT_WIDTH-1:0]   limit_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic [CNT_WIDTH-1:0]   word_idx;
    logic [FRAME_WIDTH-1:0] frame_cnt;

    logic                   start_run;
    logic                   wr;
    logic                   enter_gap;
    logic                   frame_end;
    logic [CNT_WIDTH-1:0]   last_idx;

    // LIMIT = 0 wraps to all-ones here, giving a full 2^CNT_WIDTH-word frame.
    assign last_idx  = limit_q - CNT_WIDTH'(1);
    assign frame_end = (word_idx == last_idx);

    assign fifo.TEST_OUT = {frame_cnt, word_idx};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a missing
        // branch assignment would otherwise infer a latch.
        state_d    = state_q;
        start_run  = 1'b0;
        wr         = 1'b0;
        enter_gap  = 1'b0;
        fifo.WR_EN = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    state_d   = S_RUN;
                    start_run = 1'b1;
                end
            end

            S_RUN: begin
                BUSY = 1'b1;
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (!fifo.FIFO_FULL) begin
                    wr         = 1'b1;
                    fifo.WR_EN = 1'b1;
                    if (frame_end) begin
                        case (mode_q)
                            M_CONTINUOUS: state_d = S_RUN;
                            M_BURST: begin
                                if (gap_q != '0) begin
                                    state_d   = S_GAP;
                                    enter_gap = 1'b1;
                                end
                            end
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end

            S_GAP: begin
                BUSY = 1'b1;
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (gap_cnt == GAP_WIDTH'(1)) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q     <= M_ONESHOT;
            limit_q    <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            word_idx   <= '0;
            frame_cnt  <= '0;
            WORD_TOTAL <= '0;
        end else begin
            if (start_run) begin
                mode_q     <= mode_t'(MODE);
                limit_q    <= LIMIT;
                gap_q      <= GAP;
                word_idx   <= '0;
                frame_cnt  <= '0;
                WORD_TOTAL <= '0;
            end else if (wr) begin
                if (WORD_TOTAL != 32'hFFFF_FFFF) begin
                    WORD_TOTAL <= WORD_TOTAL + 32'd1;
                end
                if (frame_end) begin
                    word_idx <= '0;
                    // One-shot (and reserved) runs end here, so the frame number stays put.
                    if (mode_q == M_CONTINUOUS || mode_q == M_BURST) begin
                        frame_cnt <= frame_cnt + FRAME_WIDTH'(1);
                    end
                end else begin
                    word_idx <= word_idx + CNT_WIDTH'(1);
                end
            end

            if (enter_gap) begin
                gap_cnt <= gap_q;
            end else if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_gen_fifo.sv
// Directed bench for pattern_gen_fifo: default instance plus a CNT_WIDTH=4
// instance for the LIMIT=0 full-range frame.
module tb_pattern_gen_fifo;
    logic        CLK;
    logic        RST;

    logic        start_a, stop_a;
    logic [1:0]  mode_a;
    logic [15:0] limit_a;
    logic [7:0]  gap_a;
    logic        busy_a, done_a;
    logic [31:0] total_a;

    logic        start_b, stop_b;
    logic [1:0]  mode_b;
    logic [3:0]  limit_b;
    logic [7:0]  gap_b;
    logic        busy_b, done_b;
    logic [31:0] total_b;

    int total;
    int bad;

    pattern_gen_fifo_if #(.DATA_WIDTH(32)) fifo_a ();
    pattern_gen_fifo_if #(.DATA_WIDTH(32)) fifo_b ();

    pattern_gen_fifo #(.DATA_WIDTH(32), .CNT_WIDTH(16), .GAP_WIDTH(8)) dut_a (
        .CLK        (CLK),
        .RST        (RST),
        .START      (start_a),
        .STOP       (stop_a),
        .MODE       (mode_a),
        .LIMIT      (limit_a),
        .GAP        (gap_a),
        .fifo       (fifo_a.master),
        .BUSY       (busy_a),
        .DONE       (done_a),
        .WORD_TOTAL (total_a)
    );

    pattern_gen_fifo #(.DATA_WIDTH(32), .CNT_WIDTH(4), .GAP_WIDTH(8)) dut_b (
        .CLK        (CLK),
        .RST        (RST),
        .START      (start_b),
        .STOP       (stop_b),
        .MODE       (mode_b),
        .LIMIT      (limit_b),
        .GAP        (gap_b),
        .fifo       (fifo_b.master),
        .BUSY       (busy_b),
        .DONE       (done_b),
        .WORD_TOTAL (total_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves time 1 unit after a rising edge, where inputs are changed.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look_a(input string tag, input logic wr, input logic [31:0] d,
                          input logic busy, input logic done);
        #1;
        check({tag, ".wr"}, 32'(fifo_a.WR_EN), 32'(wr));
        if (wr) check({tag, ".data"}, fifo_a.TEST_OUT, d);
        check({tag, ".busy"}, 32'(busy_a), 32'(busy));
        check({tag, ".done"}, 32'(done_a), 32'(done));
    endtask

    task automatic look_b(input string tag, input logic wr, input logic [31:0] d,
                          input logic busy, input logic done);
        #1;
        check({tag, ".wr"}, 32'(fifo_b.WR_EN), 32'(wr));
        if (wr) check({tag, ".data"}, fifo_b.TEST_OUT, d);
        check({tag, ".busy"}, 32'(busy_b), 32'(busy));
        check({tag, ".done"}, 32'(done_b), 32'(done));
    endtask

    // START sampled on the next edge; returns in the first RUN cycle.
    task automatic start_a_run(input logic [1:0] m, input logic [15:0] l, input logic [7:0] g);
        start_a = 1'b1;
        mode_a  = m;
        limit_a = l;
        gap_a   = g;
        step();
        start_a = 1'b0;
        mode_a  = 2'd0;
        limit_a = 16'd0;
        gap_a   = 8'd0;
    endtask

    logic [31:0] exp3 [7];

    initial begin
        total = 0;
        bad   = 0;
        exp3  = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0001_0000,
                  32'h0001_0001, 32'h0001_0002, 32'h0002_0000};

        RST = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; mode_a = 2'd0; limit_a = 16'd0; gap_a = 8'd0;
        start_b = 1'b0; stop_b = 1'b0; mode_b = 2'd0; limit_b = 4'd0;  gap_b = 8'd0;
        fifo_a.FIFO_FULL = 1'b0;
        fifo_b.FIFO_FULL = 1'b0;

        // Reset state
        #3;
        check("rst.wr",    32'(fifo_a.WR_EN), 32'd0);
        check("rst.data",  fifo_a.TEST_OUT,   32'd0);
        check("rst.busy",  32'(busy_a),       32'd0);
        check("rst.done",  32'(done_a),       32'd0);
        check("rst.total", total_a,           32'd0);
        step();
        step();
        RST = 1'b1;
        step();

        // One-shot, LIMIT=4, no backpressure
        step();
        start_a_run(2'd0, 16'd4, 8'd0);
        look_a("t1.w0", 1'b1, 32'd0, 1'b1, 1'b0);
        step(); look_a("t1.w1", 1'b1, 32'd1, 1'b1, 1'b0);
        step(); look_a("t1.w2", 1'b1, 32'd2, 1'b1, 1'b0);
        step(); look_a("t1.w3", 1'b1, 32'd3, 1'b1, 1'b0);
        step(); look_a("t1.done", 1'b0, 32'd0, 1'b0, 1'b1);
        check("t1.total", total_a, 32'd4);
        step(); look_a("t1.idle", 1'b0, 32'd0, 1'b0, 1'b0);

        // One-shot, LIMIT=4, FIFO_FULL for 3 cycles after word 1
        start_a_run(2'd0, 16'd4, 8'd0);
        look_a("t2.w0", 1'b1, 32'd0, 1'b1, 1'b0);
        step(); look_a("t2.w1", 1'b1, 32'd1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            fifo_a.FIFO_FULL = 1'b1;
            look_a($sformatf("t2.full%0d", k), 1'b0, 32'd0, 1'b1, 1'b0);
            check($sformatf("t2.hold%0d", k), fifo_a.TEST_OUT, 32'd2);
        end
        step();
        fifo_a.FIFO_FULL = 1'b0;
        look_a("t2.w2", 1'b1, 32'd2, 1'b1, 1'b0);
        step(); look_a("t2.w3", 1'b1, 32'd3, 1'b1, 1'b0);
        step(); look_a("t2.done", 1'b0, 32'd0, 1'b0, 1'b1);
        check("t2.total", total_a, 32'd4);

        // Continuous, LIMIT=3, STOP after 7 writes
        step();
        start_a_run(2'd1, 16'd3, 8'd0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            look_a($sformatf("t3.w%0d", i), 1'b1, exp3[i], 1'b1, 1'b0);
        end
        step();
        stop_a = 1'b1;
        look_a("t3.stop", 1'b0, 32'd0, 1'b1, 1'b0);
        step();
        stop_a = 1'b0;
        look_a("t3.idle", 1'b0, 32'd0, 1'b0, 1'b0);
        check("t3.total", total_a, 32'd7);
        step(); look_a("t3.nodone", 1'b0, 32'd0, 1'b0, 1'b0);

        // Burst, LIMIT=2, GAP=3
        start_a_run(2'd2, 16'd2, 8'd3);
        look_a("t4.f0w0", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        step(); look_a("t4.f0w1", 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step();
            look_a($sformatf("t4.gap%0d", g), 1'b0, 32'd0, 1'b1, 1'b0);
        end
        step(); look_a("t4.f1w0", 1'b1, 32'h0001_0000, 1'b1, 1'b0);
        step(); look_a("t4.f1w1", 1'b1, 32'h0001_0001, 1'b1, 1'b0);
        step();
        stop_a = 1'b1;
        look_a("t4.gapstop", 1'b0, 32'd0, 1'b1, 1'b0);
        step();
        stop_a = 1'b0;
        look_a("t4.idle", 1'b0, 32'd0, 1'b0, 1'b0);
        check("t4.total", total_a, 32'd4);

        // Reserved mode 3 behaves as one-shot
        step();
        start_a_run(2'd3, 16'd1, 8'd0);
        look_a("t5.w0", 1'b1, 32'd0, 1'b1, 1'b0);
        step(); look_a("t5.done", 1'b0, 32'd0, 1'b0, 1'b1);
        check("t5.total", total_a, 32'd1);

        // CNT_WIDTH=4 instance, LIMIT=0 -> 16-word frame
        step();
        start_b = 1'b1;
        mode_b  = 2'd0;
        limit_b = 4'd0;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            look_b($sformatf("t6.w%0d", i), 1'b1, 32'(i), 1'b1, 1'b0);
        end
        step(); look_b("t6.done", 1'b0, 32'd0, 1'b0, 1'b1);
        check("t6.total", total_b, 32'd16);

        // Reset mid-run, then START+STOP together, then clean START
        step();
        start_a_run(2'd1, 16'd3, 8'd0);
        look_a("t7.w0", 1'b1, 32'd0, 1'b1, 1'b0);
        step(); look_a("t7.w1", 1'b1, 32'd1, 1'b1, 1'b0);
        RST = 1'b0;
        #1;
        check("t7.rst.wr",    32'(fifo_a.WR_EN), 32'd0);
        check("t7.rst.data",  fifo_a.TEST_OUT,   32'd0);
        check("t7.rst.busy",  32'(busy_a),       32'd0);
        check("t7.rst.done",  32'(done_a),       32'd0);
        check("t7.rst.total", total_a,           32'd0);
        step();
        RST = 1'b1;
        look_a("t7.idle0", 1'b0, 32'd0, 1'b0, 1'b0);
        step(); look_a("t7.idle1", 1'b0, 32'd0, 1'b0, 1'b0);
        start_a = 1'b1;
        stop_a  = 1'b1;
        mode_a  = 2'd1;
        limit_a = 16'd3;
        step();
        start_a = 1'b0;
        stop_a  = 1'b0;
        look_a("t7.startstop", 1'b0, 32'd0, 1'b0, 1'b0);
        step(); look_a("t7.idle2", 1'b0, 32'd0, 1'b0, 1'b0);
        start_a_run(2'd0, 16'd2, 8'd0);
        look_a("t7.w0b", 1'b1, 32'd0, 1'b1, 1'b0);
        step(); look_a("t7.w1b", 1'b1, 32'd1, 1'b1, 1'b0);
        step(); look_a("t7.done", 1'b0, 32'd0, 1'b0, 1'b1);
        check("t7.total", total_a, 32'd2);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_gen_fifo.md
# pattern_gen_fifo

Parametrised test-pattern generator that streams a structured word sequence into a downstream FIFO write port for readout/link bring-up. Supports one-shot, continuous and gapped-burst modes, honours FIFO backpressure, and stamps each word with a frame number and word index. It sits between run control (START/STOP) and the user data FIFO, replacing the fixed 0..100 counter source.

## Interface
Parameters:
- DATA_WIDTH, 32, width of TEST_OUT; must be > CNT_WIDTH
- CNT_WIDTH, 16, width of word index and LIMIT
- GAP_WIDTH, 8, width of GAP

Ports:
- CLK  in  1  single clock, all logic rising-edge
- RST  in  1  reset, asynchronous, active-low; all registers cleared on assertion
- START  in  1  level-sampled; begins a run when in IDLE
- STOP  in  1  level-sampled; aborts any run, highest priority
- MODE  in  2  0 one-shot, 1 continuous, 2 burst, 3 reserved (behaves as 0); latched at START
- LIMIT  in  CNT_WIDTH  words per frame; 0 means 2^CNT_WIDTH; latched at START
- GAP  in  GAP_WIDTH  idle cycles between bursts (mode 2); latched at START
- FIFO_FULL  in  1  downstream full; no write while high
- TEST_OUT  out  DATA_WIDTH  {frame_cnt, word_idx}; frame_cnt occupies upper DATA_WIDTH-CNT_WIDTH bits
- WR_EN  out  1  write strobe; one word accepted per high cycle
- BUSY  out  1  high in RUN and GAP
- DONE  out  1  one-cycle pulse on one-shot completion
- WORD_TOTAL  out  32  words written since last START, saturates at 0xFFFF_FFFF

## Operation
- States: IDLE, RUN, GAP, DONE. Reset: IDLE; TEST_OUT, WR_EN, BUSY, DONE, WORD_TOTAL, word_idx, frame_cnt all 0.
- IDLE: START=1 and STOP=0 -> latch MODE/LIMIT/GAP, clear word_idx, frame_cnt, WORD_TOTAL -> RUN. START ignored outside IDLE.
- RUN: WR_EN = !FIFO_FULL (combinational from state and FIFO_FULL). On a write cycle word_idx increments and WORD_TOTAL increments (saturating). FIFO_FULL=1: WR_EN=0, all counters hold.
- End of frame = write cycle with word_idx == LIMIT-1 (mod 2^CNT_WIDTH). Then:
  - mode 0/3: -> DONE; word_idx wraps to 0.
  - mode 1: word_idx -> 0, frame_cnt +1 (wraps mod 2^(DATA_WIDTH-CNT_WIDTH)), stay RUN.
  - mode 2: word_idx -> 0, frame_cnt +1; GAP==0 stay RUN, else -> GAP with gap counter loaded to GAP.
- GAP: WR_EN=0; gap counter decrements each cycle; -> RUN on the cycle it reaches 1 (exactly GAP idle cycles).
- DONE: DONE=1, BUSY=0, WR_EN=0 for one cycle -> IDLE.
- STOP=1 in RUN or GAP: -> IDLE next edge; no write in the STOP cycle (WR_EN forced 0). DONE not pulsed. WORD_TOTAL holds its value until next START.
- STOP and START together in IDLE: stay IDLE.
- TEST_OUT is the registered {frame_cnt, word_idx} and is valid whenever WR_EN=1; holds last value in IDLE.
- RST deassertion mid-run: block restarts in IDLE; requires a fresh START.

## Timing
- START sampled at edge N -> RUN from cycle N+1; first word (TEST_OUT=0) written in N+1 if FIFO_FULL=0.
- Throughput: one word per cycle while FIFO_FULL=0; zero bubbles across frame boundaries in modes 1 and 2 with GAP=0.
- FIFO_FULL affects WR_EN in the same cycle (zero latency); data not advanced until the write occurs.
- One-shot with LIMIT=L, no backpressure: writes in cycles N+1..N+L, DONE in N+L+1, IDLE and BUSY=0 from N+L+1.
- Burst: last word of frame in cycle K, GAP=G>0 -> WR_EN=0 in K+1..K+G, next frame first word in K+G+1.

## Test plan
- Mode 0, LIMIT=4, FIFO_FULL=0: TEST_OUT 0,1,2,3 on four consecutive WR_EN cycles, DONE one cycle later, WORD_TOTAL=4.
- Mode 0, LIMIT=4, FIFO_FULL high for 3 cycles after word 1: WR_EN low those cycles, TEST_OUT holds 2, sequence resumes 2,3; exactly 4 writes.
- Mode 1, LIMIT=3, STOP after 7 writes: TEST_OUT 0x00000000,1,2,0x00010000,0x00010001,0x00010002,0x00020000; IDLE next cycle, no DONE, WORD_TOTAL=7.
- Mode 2, LIMIT=2, GAP=3: two writes, three idle cycles with BUSY=1, then frame 1 words 0x00010000,0x00010001.
- Mode 0, LIMIT=0, CNT_WIDTH=4 override: 16 writes 0..15 then DONE.
- RST asserted mid-RUN and START asserted together with STOP in IDLE: all outputs 0 asynchronously; no run started until clean START.
